// File: rtl/dbu_pkg.sv
// dbu_pkg: shared definitions for the debug-unit button front end.
//   - Button channel indices (step, inc, dec).
//   - Per-channel FSM state encoding.
//   - Default timing constants for a 100 MHz system clock.
//   - A small elaboration-time helper for sizing counters.
`timescale 1ns/1ps
package dbu_pkg;

  // Bit positions of each button within the btn_in/level/pulse/held vectors.
  localparam int BTN_STEP = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_DEC  = 2;

  // Default timing at 100 MHz: 10 ms debounce, 500 ms to first repeat,
  // then one repeat every 100 ms.
  localparam int DB_CYCLES_100MHZ  = 1_000_000;
  localparam int RPT_DELAY_100MHZ  = 50_000_000;
  localparam int RPT_PERIOD_100MHZ = 10_000_000;

  // Channel FSM: IDLE until a debounced press, HELD while waiting for the
  // first repeat, REPEAT while emitting periodic repeat pulses.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: conditioning for one push-button.
//   Two-flop synchroniser -> debouncer -> press/repeat FSM.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   btn_raw  in  1  raw asynchronous, bouncing button level (active-high)
//   level    out 1  debounced button level
//   pulse    out 1  one-cycle strobe per accepted press and per repeat
//   held     out 1  high while the FSM is not IDLE
`timescale 1ns/1ps
module btn_channel
  import dbu_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_100MHZ,
  parameter int RPT_DELAY  = RPT_DELAY_100MHZ,
  parameter int RPT_PERIOD = RPT_PERIOD_100MHZ,
  parameter bit RPT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse,
  output logic held
);

  localparam int DW = $clog2(DB_CYCLES);
  localparam int RW = $clog2(max_int(RPT_DELAY, RPT_PERIOD));

  localparam logic [DW-1:0] DB_LAST     = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD - 1);

  logic          s1_reg, s2_reg;
  logic [DW-1:0] dcnt_reg;
  logic          level_reg;
  btn_state_e    state_reg, state_next;
  logic [RW-1:0] rcnt_reg, rcnt_next;
  logic          pulse_reg, pulse_next;
  logic          held_reg, held_next;

  // Synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= btn_raw;
      s2_reg <= s1_reg;
    end
  end

  // Debouncer: the synchronised level must disagree with the accepted level
  // for DB_CYCLES consecutive samples; any return to the old level restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_reg  <= '0;
      level_reg <= 1'b0;
    end else if (s2_reg == level_reg) begin
      dcnt_reg <= '0;
    end else if (dcnt_reg == DB_LAST) begin
      level_reg <= s2_reg;
      dcnt_reg  <= '0;
    end else begin
      dcnt_reg <= dcnt_reg + 1'b1;
    end
  end

  // Press / auto-repeat FSM. Release is tested first in every state, so a
  // release coinciding with a repeat deadline suppresses that pulse.
  always_comb begin
    state_next = state_reg;
    rcnt_next  = rcnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        rcnt_next = '0;
        if (level_reg) begin
          pulse_next = 1'b1;
          state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!level_reg) begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end else if (RPT_EN) begin
          if (rcnt_reg == DELAY_LAST) begin
            pulse_next = 1'b1;
            rcnt_next  = '0;
            state_next = ST_REPEAT;
          end else begin
            rcnt_next = rcnt_reg + 1'b1;
          end
        end else begin
          rcnt_next = '0;
        end
      end
      ST_REPEAT: begin
        if (!level_reg) begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end else if (rcnt_reg == PERIOD_LAST) begin
          pulse_next = 1'b1;
          rcnt_next  = '0;
        end else begin
          rcnt_next = rcnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        rcnt_next  = '0;
      end
    endcase
    // held is registered from the next state so it rises with the press
    // pulse and falls on the edge the FSM returns to IDLE.
    held_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      rcnt_reg  <= '0;
      pulse_reg <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
      pulse_reg <= pulse_next;
      held_reg  <= held_next;
    end
  end

  assign level = level_reg;
  assign pulse = pulse_reg;
  assign held  = held_reg;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: front end for the debug-unit push-buttons (step, inc,
// dec). Each channel is synchronised, debounced and turned into single-cycle
// press pulses; channels enabled in RPT_MASK also auto-repeat while held.
// Ports:
//   clk     in  1     system clock (100 MHz)
//   rst     in  1     synchronous active-high reset
//   btn_in  in  NBTN  raw asynchronous button levels, active-high
//   level   out NBTN  debounced button levels
//   pulse   out NBTN  one-cycle strobe per press and per repeat
//   held    out NBTN  high while a channel's FSM is not IDLE
`timescale 1ns/1ps
module btn_conditioner
  import dbu_pkg::*;
#(
  parameter int              NBTN       = 3,
  parameter int              DB_CYCLES  = DB_CYCLES_100MHZ,
  parameter int              RPT_DELAY  = RPT_DELAY_100MHZ,
  parameter int              RPT_PERIOD = RPT_PERIOD_100MHZ,
  parameter logic [NBTN-1:0] RPT_MASK   = 3'b110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] level,
  output logic [NBTN-1:0] pulse,
  output logic [NBTN-1:0] held
);

  // Channels are fully independent; no cross-channel arbitration.
  for (genvar gi = 0; gi < NBTN; gi++) begin : g_chan
    btn_channel #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD),
      .RPT_EN    (RPT_MASK[gi])
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_in[gi]),
      .level  (level[gi]),
      .pulse  (pulse[gi]),
      .held   (held[gi])
    );
  end

endmodule
